// File: rtl/spell_pkg.sv
// Shared types and default timing constants for the spell-counter button front end.
package spell_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 20000;
  localparam int REPEAT_DELAY_DEF    = 500000;
  localparam int REPEAT_PERIOD_DEF   = 100000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spell_debounce_channel.sv
// One button channel: 2-flop synchroniser, polarity normalise, debounce FSM.
// Optional auto-repeat hold counter under SPELL_DEBOUNCE_AUTOREPEAT_EN.
module spell_debounce_channel
  import spell_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int ACTIVE_LOW      = 1
`ifdef SPELL_DEBOUNCE_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam logic          IDLE_LVL = (ACTIVE_LOW != 0);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic sync1, sync2, sample;

  // NOTE: synchroniser resets to the released level so leaving reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= IDLE_LVL;
      sync2 <= IDLE_LVL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign sample = sync2 ^ IDLE_LVL;

  deb_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          level_n, press_n, rel_n;

`ifdef SPELL_DEBOUNCE_AUTOREPEAT_EN
  localparam int            HW        = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [HW-1:0] HOLD_DLY  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_PER  = HW'(REPEAT_PERIOD - 1);
  logic [HW-1:0] hold, hold_n;
  logic          rep_phase, rep_phase_n;
`endif

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level;
    press_n = 1'b0;
    rel_n   = 1'b0;
`ifdef SPELL_DEBOUNCE_AUTOREPEAT_EN
    hold_n      = hold;
    rep_phase_n = rep_phase;
`endif
    if (ena) begin
      unique case (state)
        RELEASED: begin
          if (sample) begin
            state_n = PRESS_WAIT;
            cnt_n   = CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sample) begin
            state_n = RELEASED;
            cnt_n   = '0;
          end else if (cnt == CNT_LAST) begin
            state_n = PRESSED;
            cnt_n   = '0;
            level_n = 1'b1;
            press_n = 1'b1;
`ifdef SPELL_DEBOUNCE_AUTOREPEAT_EN
            hold_n      = '0;
            rep_phase_n = 1'b0;
`endif
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!sample) begin
            state_n = RELEASE_WAIT;
            cnt_n   = CW'(1);
          end else begin
`ifdef SPELL_DEBOUNCE_AUTOREPEAT_EN
            // First repeat after the delay, then one every period.
            if (hold == (rep_phase ? HOLD_PER : HOLD_DLY)) begin
              press_n     = 1'b1;
              hold_n      = '0;
              rep_phase_n = 1'b1;
            end else begin
              hold_n = hold + HW'(1);
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          if (sample) begin
            state_n = PRESSED;
            cnt_n   = '0;
          end else if (cnt == CNT_LAST) begin
            state_n = RELEASED;
            cnt_n   = '0;
            level_n = 1'b0;
            rel_n   = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = RELEASED;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
`ifdef SPELL_DEBOUNCE_AUTOREPEAT_EN
      hold      <= '0;
      rep_phase <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
      press <= press_n;
      rel   <= rel_n;
`ifdef SPELL_DEBOUNCE_AUTOREPEAT_EN
      hold      <= hold_n;
      rep_phase <= rep_phase_n;
`endif
    end
  end

endmodule

// File: rtl/spell_button_debouncer.sv
// Debounces NUM_BTN raw push-buttons into clean levels and press/release pulses.
// Build option: define SPELL_DEBOUNCE_AUTOREPEAT_EN for held-button auto-repeat.
module spell_button_debouncer
  import spell_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("spell_button_debouncer: illegal timing parameter");
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    spell_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
`ifdef SPELL_DEBOUNCE_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end

endmodule

// File: tb/tb_spell_button_debouncer.sv
// Scoreboard bench: a run-length reference model predicts pulses, a monitor checks them.
module tb_spell_button_debouncer;

  localparam int NB = 4;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b1;
  logic [NB-1:0] btn_raw = '1;
  logic [NB-1:0] btn_level, btn_press, btn_release;

  always #5 clk = ~clk;

  spell_button_debouncer #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW     (1),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  typedef struct {
    int            cyc;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
  } ev_t;

  ev_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  int  press_cnt[NB];
  int  rel_cnt[NB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a level flips after D consecutive enabled samples disagreeing with it.
  logic [NB-1:0] m_s1, m_s2, m_level, m_samp, m_pr, m_rl;
  int            m_run[NB];
  int            m_hold[NB];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_s1    = '1;
      m_s2    = '1;
      m_level = '0;
      for (int i = 0; i < NB; i++) begin
        m_run[i]  = 0;
        m_hold[i] = 0;
      end
    end else begin
      m_samp = ~m_s2;
      m_s2   = m_s1;
      m_s1   = btn_raw;
      m_pr   = '0;
      m_rl   = '0;
      if (ena) begin
        for (int i = 0; i < NB; i++) begin
          if (m_samp[i] != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == D) begin
              m_level[i] = m_samp[i];
              m_run[i]   = 0;
              m_hold[i]  = 0;
              if (m_samp[i]) m_pr[i] = 1'b1;
              else           m_rl[i] = 1'b1;
            end
          end else begin
            if (m_level[i] && m_run[i] == 0) begin
              m_hold[i]++;
`ifdef SPELL_DEBOUNCE_AUTOREPEAT_EN
              if (m_hold[i] == RD || (m_hold[i] > RD && (m_hold[i] - RD) % RP == 0))
                m_pr[i] = 1'b1;
`endif
            end
            m_run[i] = 0;
          end
        end
      end
      if ((m_pr | m_rl) != '0) sb_q.push_back('{cyc, m_pr, m_rl});
    end
  end

  // Monitor: samples on the falling edge, pops expected events when the DUT pulses.
  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs", {btn_level, btn_press, btn_release}, '0);
      sb_q.delete();
    end else begin
      check("level", btn_level, m_level);
      for (int i = 0; i < NB; i++) begin
        press_cnt[i] += int'(btn_press[i]);
        rel_cnt[i]   += int'(btn_release[i]);
      end
      if ((btn_press | btn_release) != '0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {btn_press, btn_release}, '0);
        end else begin
          ev_t e;
          e = sb_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_press", btn_press, e.press);
          check("pulse_release", btn_release, e.rel);
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        check("missed_pulse", {btn_press, btn_release}, {sb_q[0].press, sb_q[0].rel});
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the number of rising edges up to and including the one that raised btn_press[ch].
  task automatic edges_to_press(input int ch, output int k);
    k = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      #1;
      k++;
      if (btn_press[ch]) break;
    end
  endtask

  int hold_left[NB];

  initial begin
    int k, p0, r0, exp_rep;
    for (int i = 0; i < NB; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
      hold_left[i] = 1;
    end

    tick(3);
    #2 rst = 1'b0;

    // Idle with all buttons released.
    tick(100);
    check("idle_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    check("idle_level", btn_level, 4'h0);

    // Half-period glitch on channel 3 that straddles no rising edge.
    @(posedge clk);
    #2 btn_raw[3] = 1'b0;
    #5 btn_raw[3] = 1'b1;
    tick(12);
    check("glitch_press3", press_cnt[3], 0);
    check("glitch_level3", btn_level[3], 1'b0);

    // Clean press on channel 0, measure latency, then hold for auto-repeat.
    p0 = press_cnt[0];
    btn_raw[0] = 1'b0;
    edges_to_press(0, k);
    check("press0_latency_edges", k, 6);
    repeat (59) @(posedge clk);
    #1;
`ifdef SPELL_DEBOUNCE_AUTOREPEAT_EN
    exp_rep = 6;
`else
    exp_rep = 1;
`endif
    check("press0_pulse_count", press_cnt[0] - p0, exp_rep);
    check("press0_level", btn_level[0], 1'b1);
    tick(1);
    r0 = rel_cnt[0];
    btn_raw[0] = 1'b1;
    tick(10);
    check("release0_count", rel_cnt[0] - r0, 1);

    // Bouncing press and release on channel 1.
    p0 = press_cnt[1];
    btn_raw[1] = 1'b0; tick(2);
    btn_raw[1] = 1'b1; tick(2);
    btn_raw[1] = 1'b0; tick(2);
    btn_raw[1] = 1'b1; tick(2);
    btn_raw[1] = 1'b0; tick(12);
    check("bounce_press1_count", press_cnt[1] - p0, 1);
    r0 = rel_cnt[1];
    btn_raw[1] = 1'b1; tick(2);
    btn_raw[1] = 1'b0; tick(2);
    btn_raw[1] = 1'b1; tick(2);
    btn_raw[1] = 1'b0; tick(2);
    btn_raw[1] = 1'b1; tick(12);
    check("bounce_release1_count", rel_cnt[1] - r0, 1);

    // Reset in the middle of channel 2's debounce window.
    btn_raw[2] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("midreset_outputs", {btn_level, btn_press, btn_release}, '0);
    tick(2);
    #2 rst = 1'b0;
    edges_to_press(2, k);
    check("press2_after_reset_edges", k, 6);
    tick(1);
    btn_raw[2] = 1'b1;
    tick(10);

    // Randomised bouncing on all channels with occasional ena drops.
    for (int c = 0; c < 1500; c++) begin
      tick(1);
      ena = ($urandom_range(0, 19) != 0);
      for (int i = 0; i < NB; i++) begin
        hold_left[i]--;
        if (hold_left[i] <= 0) begin
          btn_raw[i]   = 1'($urandom_range(0, 1));
          hold_left[i] = int'($urandom_range(1, 10));
        end
      end
    end

    ena     = 1'b1;
    btn_raw = '1;
    tick(30);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
